// File: rtl/ipsxe_floating_point_unary_arb_v1_0.sv
// -----------------------------------------------------------------------------
// ipsxe_floating_point_unary_arb_v1_0
//
// Round-robin arbiter that shares one floating-point sign-manipulation unit
// (abs / negate / pass / nabs) among NREQ AXI4-Stream requesters. The winning
// operand has its sign bit rewritten and is queued, tagged with its channel
// id, in a 2-entry output FIFO.
//
// Ports:
//   i_aclk, i_rst            clock, synchronous active-high reset
//   i_axi4s_a_tdata          NREQ packed operands, channel k at [k*WIDTH +: WIDTH]
//   i_axi4s_a_tuser          NREQ packed 2-bit opcodes, channel k at [2k +: 2]
//   i_axi4s_a_tvalid         per-channel request valid
//   o_axi4s_a_tready         per-channel ready, at most one bit high
//   o_axi4s_result_tdata     FIFO head result word
//   o_axi4s_result_tuser     FIFO head channel id, zero-extended to 3 bits
//   o_axi4s_result_tvalid    FIFO not empty
//   i_axi4s_result_tready    consumer ready
//
// Configuration macro: IPSXE_FLOATING_POINT_UNARY_ARB_OPCODE_EN
//   defined   - i_axi4s_a_tuser selects the sign operation
//   undefined - opcode ignored, every transfer performs abs
// -----------------------------------------------------------------------------
module ipsxe_floating_point_unary_arb_v1_0 #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                  i_aclk,
    input  logic                  i_rst,
    input  logic [NREQ*WIDTH-1:0] i_axi4s_a_tdata,
    input  logic [2*NREQ-1:0]     i_axi4s_a_tuser,
    input  logic [NREQ-1:0]       i_axi4s_a_tvalid,
    output logic [NREQ-1:0]       o_axi4s_a_tready,
    output logic [WIDTH-1:0]      o_axi4s_result_tdata,
    output logic [2:0]            o_axi4s_result_tuser,
    output logic                  o_axi4s_result_tvalid,
    input  logic                  i_axi4s_result_tready
);

    localparam int ID_W = 3;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [ID_W-1:0]  id_t;

    id_t        ptr_q,  ptr_d;
    logic [1:0] count_q, count_d;
    word_t      data_q [2];
    word_t      data_d [2];
    id_t        id_q   [2];
    id_t        id_d   [2];

    logic  found;
    id_t   win;
    word_t sel_data;
    word_t result;
    logic  space;
    logic  push;
    logic  pop;

`ifdef IPSXE_FLOATING_POINT_UNARY_ARB_OPCODE_EN
    logic [1:0] sel_op;
`else
    logic unused_tuser;
    assign unused_tuser = ^i_axi4s_a_tuser;
`endif

    // Round-robin scan: walking j over two laps and ignoring j < ptr visits
    // channels ptr, ptr+1, ... modulo NREQ using only constant channel indices.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        sel_data = '0;
`ifdef IPSXE_FLOATING_POINT_UNARY_ARB_OPCODE_EN
        sel_op   = 2'b00;
`endif
        for (int j = 0; j < 2*NREQ; j++) begin
            if (!found && (j >= int'(ptr_q)) && i_axi4s_a_tvalid[j % NREQ]) begin
                found    = 1'b1;
                win      = id_t'(j % NREQ);
                sel_data = i_axi4s_a_tdata[(j % NREQ)*WIDTH +: WIDTH];
`ifdef IPSXE_FLOATING_POINT_UNARY_ARB_OPCODE_EN
                sel_op   = i_axi4s_a_tuser[2*(j % NREQ) +: 2];
`endif
            end
        end
    end

    // Sign-bit rewrite; the magnitude bits always pass through untouched.
    always_comb begin
        result = sel_data;
`ifdef IPSXE_FLOATING_POINT_UNARY_ARB_OPCODE_EN
        case (sel_op)
            2'b00:   result[WIDTH-1] = 1'b0;
            2'b01:   result[WIDTH-1] = ~sel_data[WIDTH-1];
            2'b10:   result[WIDTH-1] = sel_data[WIDTH-1];
            default: result[WIDTH-1] = 1'b1;
        endcase
`else
        result[WIDTH-1] = 1'b0;
`endif
    end

    // Space depends only on registered occupancy, so a slot freed by a pop
    // this cycle is not offered until the next one. Reset blocks grants.
    assign space = (count_q != 2'd2);
    assign push  = found && space && !i_rst;
    assign pop   = (count_q != 2'd0) && i_axi4s_result_tready;

    always_comb begin
        o_axi4s_a_tready = '0;
        for (int k = 0; k < NREQ; k++) begin
            o_axi4s_a_tready[k] = push && (win == id_t'(k));
        end
    end

    // FIFO: entry 0 is always the head; a pop shifts entry 1 forward. A push
    // lands in the first slot still occupied-free after that shift.
    always_comb begin
        data_d  = data_q;
        id_d    = id_q;
        count_d = count_q;
        ptr_d   = ptr_q;

        if (pop) begin
            data_d[0] = data_q[1];
            id_d[0]   = id_q[1];
        end

        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                data_d[0] = result;
                id_d[0]   = win;
            end else begin
                data_d[1] = result;
                id_d[1]   = win;
            end
            ptr_d = (win == id_t'(NREQ-1)) ? '0 : win + id_t'(1);
        end

        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            // NOTE: the FIFO storage is reset because the head entry drives
            // tdata/tuser directly and those must read zero after reset.
            for (int e = 0; e < 2; e++) begin
                data_q[e] <= '0;
                id_q[e]   <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign o_axi4s_result_tdata  = data_q[0];
    assign o_axi4s_result_tuser  = id_q[0];
    assign o_axi4s_result_tvalid = (count_q != 2'd0);

endmodule
